// File: rtl/mc_main_ctrl.sv
// ---------------------------------------------------------------------------
// mc_main_ctrl
//
// Main control FSM for a multicycle MIPS datapath. Every instruction is
// sequenced through fetch / decode / execute / memory / write-back steps.
// The block drives the datapath mux selects and write strobes and produces
// the 2-bit ALU operation code for the ALU control decoder. The mem_ready
// handshake stretches FETCH, MEM_READ and MEM_WRITE over wait states.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   opcode[5:0]    IR[31:26], only looked at in DECODE
//   func[5:0]      IR[5:0],   only looked at in DECODE
//   mem_ready      memory accepted/completed the current access this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if ALU zero
//   iord           memory address select (0 PC, 1 ALUOut)
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       instruction register load
//   mem_to_reg     write-back data select (0 ALUOut, 1 MDR)
//   reg_dst        destination select (0 rt, 1 rd)
//   reg_write      register file write
//   alu_src_a      ALU A select (0 PC, 1 register A)
//   alu_src_b[1:0] ALU B select (B, 4, imm, imm<<2)
//   alu_op[1:0]    00 add, 01 subtract, 10 use func
//   pc_source[1:0] ALU result, ALUOut, jump target, register A
//   illegal_op     one-cycle pulse on an unrecognised opcode
//   state[3:0]     current state, for debug
// ---------------------------------------------------------------------------
module mc_main_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] FN_JR   = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_JR        = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    state_t r_state;
    state_t w_state_next;
    // Load/store direction captured in DECODE so MEM_ADDR does not depend on
    // opcode still being stable later in the instruction.
    logic   r_is_store;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_is_store <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) begin
                r_is_store <= (opcode == OP_SW);
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        state         = r_state;

        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR load and PC+4 commit only once the fetch completes.
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;   // branch target precompute
                case (opcode)
                    OP_LW, OP_SW: w_state_next = S_MEM_ADDR;
                    OP_R:         w_state_next = (func == FN_JR) ? S_JR : S_R_EXEC;
                    OP_BEQ:       w_state_next = S_BRANCH;
                    OP_J:         w_state_next = S_JUMP;
                    OP_ADDI:      w_state_next = S_ADDI_EXEC;
                    default: begin
                        illegal_op   = 1'b1;
                        w_state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_state_next = r_is_store ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    w_state_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    w_state_next = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a    = 1'b1;
                alu_op       = 2'b10;
                w_state_next = S_R_WB;
            end
            S_R_WB: begin
                reg_write    = 1'b1;
                reg_dst      = 1'b1;
                w_state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                w_state_next  = S_FETCH;
            end
            S_JUMP: begin
                pc_write     = 1'b1;
                pc_source    = 2'b10;
                w_state_next = S_FETCH;
            end
            S_JR: begin
                pc_write     = 1'b1;
                pc_source    = 2'b11;
                w_state_next = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_state_next = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write    = 1'b1;
                w_state_next = S_FETCH;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase

        // While reset is held every output is forced low immediately, so a
        // pending memory request is dropped in the same cycle reset appears.
        if (!rst_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            pc_source     = 2'b00;
            illegal_op    = 1'b0;
            state         = 4'd0;
        end
    end

endmodule
